fb_pingpong_writer: RTL and testbench

//  Sequences camera pixel words from the MIPI receiver into the shared dual-port frame RAM as two ping-pong frame buffers.

---
 rtl/fb_pingpong_writer.sv | 221 ++++++++++++++++++++++
 tb/tb_fb_pingpong_writer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pingpong_writer.sv
// Ping-pong frame-buffer writer: steers camera words into one RAM bank while the display reads the other.
// Optional build macro FB_STATS_EN adds saturating frames_done / frames_dropped counters.
module fb_pingpong_writer #(
   parameter int H_WORDS = 80,
   parameter int V_LINES = 240,
   parameter int ADDR_W  = 17
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              frame_start,
   input  logic              line_start,
   input  logic              pix_valid,
   input  logic [31:0]       pix_data,
   input  logic              rd_vsync,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              rd_bank,
   output logic [ADDR_W-1:0] rd_base,
   output logic              busy,
   output logic              swap_pending
`ifdef FB_STATS_EN
   ,
   output logic [15:0]       frames_done,
   output logic [15:0]       frames_dropped
`endif
);

   localparam int WW = $clog2(H_WORDS + 1);
   localparam int LW = $clog2(V_LINES + 1);
   localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(H_WORDS * V_LINES);
   localparam logic [WW-1:0]     WORD_MAX    = WW'(H_WORDS);
   localparam logic [WW-1:0]     WORD_LAST   = WW'(H_WORDS - 1);
   localparam logic [LW-1:0]     LINE_LAST   = LW'(V_LINES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_FS = 2'd1,
      S_ACTIVE  = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t            state_r;
   logic [WW-1:0]     word_r;
   logic [LW-1:0]     line_r;
   logic [ADDR_W-1:0] line_base_r;
   logic              wb_r;
   logic              rd_bank_r;
   logic [ADDR_W-1:0] rd_base_r;
   logic              wr_en_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [31:0]       wr_data_r;
   logic              busy_r;
   logic              swap_pending_r;

   logic [ADDR_W-1:0] wr_addr_s;
   logic              word_ok_s;
   logic              last_write_s;

   // Next write address and end-of-frame detection for the current counters
   always_comb begin
      wr_addr_s    = (wb_r ? FRAME_WORDS : {ADDR_W{1'b0}}) + line_base_r + ADDR_W'(word_r);
      word_ok_s    = (word_r < WORD_MAX);
      last_write_s = 1'b0;
      if ((word_r == WORD_LAST) && (line_r == LINE_LAST)) begin
         last_write_s = 1'b1;
      end else begin
         last_write_s = 1'b0;
      end
   end

   // Capture FSM: counters, bank swap and registered RAM write port
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state_r        <= S_IDLE;
         word_r         <= {WW{1'b0}};
         line_r         <= {LW{1'b0}};
         line_base_r    <= {ADDR_W{1'b0}};
         wb_r           <= 1'b0;
         rd_bank_r      <= 1'b1;
         rd_base_r      <= FRAME_WORDS;
         wr_en_r        <= 1'b0;
         wr_addr_r      <= {ADDR_W{1'b0}};
         wr_data_r      <= 32'd0;
         busy_r         <= 1'b0;
         swap_pending_r <= 1'b0;
      end else begin
         wr_en_r <= 1'b0;
         if (!enable) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
         end else begin
            case (state_r)
               S_IDLE: begin
                  state_r <= S_WAIT_FS;
               end
               S_WAIT_FS: begin
                  if (frame_start) begin
                     state_r        <= S_ACTIVE;
                     busy_r         <= 1'b1;
                     word_r         <= {WW{1'b0}};
                     line_r         <= {LW{1'b0}};
                     line_base_r    <= {ADDR_W{1'b0}};
                     swap_pending_r <= 1'b0;
                  end
               end
               S_ACTIVE: begin
                  if (frame_start) begin
                     word_r      <= {WW{1'b0}};
                     line_r      <= {LW{1'b0}};
                     line_base_r <= {ADDR_W{1'b0}};
                  end else if (line_start) begin
                     // First line_start of a frame (word==0) and overflow lines are ignored
                     if ((word_r != {WW{1'b0}}) && (line_r != LINE_LAST)) begin
                        line_r      <= line_r + LW'(1);
                        line_base_r <= line_base_r + ADDR_W'(H_WORDS);
                        word_r      <= {WW{1'b0}};
                     end
                  end else if (pix_valid && word_ok_s) begin
                     wr_en_r   <= 1'b1;
                     wr_addr_r <= wr_addr_s;
                     wr_data_r <= pix_data;
                     word_r    <= word_r + WW'(1);
                     if (last_write_s) begin
                        state_r        <= S_DONE;
                        busy_r         <= 1'b0;
                        swap_pending_r <= 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  if (rd_vsync && swap_pending_r) begin
                     wb_r           <= ~wb_r;
                     rd_bank_r      <= ~rd_bank_r;
                     rd_base_r      <= rd_bank_r ? {ADDR_W{1'b0}} : FRAME_WORDS;
                     swap_pending_r <= 1'b0;
                  end
                  if (frame_start) begin
                     state_r        <= S_ACTIVE;
                     busy_r         <= 1'b1;
                     word_r         <= {WW{1'b0}};
                     line_r         <= {LW{1'b0}};
                     line_base_r    <= {ADDR_W{1'b0}};
                     swap_pending_r <= 1'b0;
                  end
               end
               default: begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign wr_en        = wr_en_r;
   assign wr_addr      = wr_addr_r;
   assign wr_data      = wr_data_r;
   assign rd_bank      = rd_bank_r;
   assign rd_base      = rd_base_r;
   assign busy         = busy_r;
   assign swap_pending = swap_pending_r;

`ifdef FB_STATS_EN
   logic [15:0] frames_done_r;
   logic [15:0] frames_dropped_r;
   logic        done_evt_s;
   logic        drop_evt_s;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   // Frame completion and abort events, mirroring the FSM decisions
   always_comb begin
      done_evt_s = 1'b0;
      drop_evt_s = 1'b0;
      if (!enable) begin
         drop_evt_s = (state_r == S_ACTIVE);
      end else begin
         case (state_r)
            S_ACTIVE: begin
               if (frame_start) begin
                  drop_evt_s = 1'b1;
               end else if (!line_start && pix_valid && word_ok_s && last_write_s) begin
                  done_evt_s = 1'b1;
               end else begin
                  done_evt_s = 1'b0;
               end
            end
            S_DONE: begin
               if (frame_start && swap_pending_r && !rd_vsync) begin
                  drop_evt_s = 1'b1;
               end else begin
                  drop_evt_s = 1'b0;
               end
            end
            default: begin
               drop_evt_s = 1'b0;
            end
         endcase
      end
   end

   // Saturating statistics counters
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         frames_done_r    <= 16'd0;
         frames_dropped_r <= 16'd0;
      end else begin
         if (done_evt_s) frames_done_r <= sat_inc(frames_done_r);
         if (drop_evt_s) frames_dropped_r <= sat_inc(frames_dropped_r);
      end
   end

   assign frames_done    = frames_done_r;
   assign frames_dropped = frames_dropped_r;
`endif

endmodule

// File: tb/tb_fb_pingpong_writer.sv
// Directed self-checking bench for fb_pingpong_writer with a 4x3-word frame.
module tb_fb_pingpong_writer;

   localparam int H_WORDS = 4;
   localparam int V_LINES = 3;
   localparam int ADDR_W  = 17;

   logic              sys_clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              frame_start;
   logic              line_start;
   logic              pix_valid;
   logic [31:0]       pix_data;
   logic              rd_vsync;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              rd_bank;
   logic [ADDR_W-1:0] rd_base;
   logic              busy;
   logic              swap_pending;
`ifdef FB_STATS_EN
   logic [15:0]       frames_done;
   logic [15:0]       frames_dropped;
`endif

   int checks   = 0;
   int failures = 0;

   fb_pingpong_writer #(.H_WORDS(H_WORDS), .V_LINES(V_LINES), .ADDR_W(ADDR_W)) dut (
      .sys_clk      (sys_clk),
      .reset        (reset),
      .enable       (enable),
      .frame_start  (frame_start),
      .line_start   (line_start),
      .pix_valid    (pix_valid),
      .pix_data     (pix_data),
      .rd_vsync     (rd_vsync),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_bank      (rd_bank),
      .rd_base      (rd_base),
      .busy         (busy),
      .swap_pending (swap_pending)
`ifdef FB_STATS_EN
      ,
      .frames_done    (frames_done),
      .frames_dropped (frames_dropped)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic pulse_ls();
      line_start = 1'b1;
      step();
      line_start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] data, input logic [31:0] exp_addr);
      pix_valid = 1'b1;
      pix_data  = data;
      step();
      pix_valid = 1'b0;
      chk("wr_en", {31'd0, wr_en}, 32'd1);
      chk("wr_addr", {15'd0, wr_addr}, exp_addr);
      chk("wr_data", wr_data, data);
   endtask

   task automatic send_dropped();
      pix_valid = 1'b1;
      pix_data  = 32'hDEAD_BEEF;
      step();
      pix_valid = 1'b0;
      chk("wr_en_dropped", {31'd0, wr_en}, 32'd0);
   endtask

   task automatic run_frame(input logic [31:0] base, input bit do_fs);
      if (do_fs) begin
         pulse_fs();
         chk("busy_active", {31'd0, busy}, 32'd1);
      end
      for (int l = 0; l < V_LINES; l++) begin
         pulse_ls();
         for (int w = 0; w < H_WORDS; w++) begin
            send_word(32'hA500_0000 + base + l * H_WORDS + w, base + l * H_WORDS + w);
         end
      end
      chk("pending_done", {31'd0, swap_pending}, 32'd1);
      chk("busy_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
      chk({tag, "_wr_addr"}, {15'd0, wr_addr}, 32'd0);
      chk({tag, "_wr_data"}, wr_data, 32'd0);
      chk({tag, "_rd_bank"}, {31'd0, rd_bank}, 32'd1);
      chk({tag, "_rd_base"}, {15'd0, rd_base}, 32'd12);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_pending"}, {31'd0, swap_pending}, 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      enable      = 1'b0;
      frame_start = 1'b0;
      line_start  = 1'b0;
      pix_valid   = 1'b0;
      pix_data    = 32'd0;
      rd_vsync    = 1'b0;
      step();
      step();
      chk_reset_outputs("reset");

      // Frame 1 into bank 0
      reset  = 1'b0;
      enable = 1'b1;
      step();
      chk("busy_wait_fs", {31'd0, busy}, 32'd0);
      run_frame(32'd0, 1'b1);
      chk("rd_bank_f1", {31'd0, rd_bank}, 32'd1);

      // Swap on vsync
      rd_vsync = 1'b1;
      step();
      rd_vsync = 1'b0;
      chk("rd_bank_swap1", {31'd0, rd_bank}, 32'd0);
      chk("rd_base_swap1", {15'd0, rd_base}, 32'd0);
      chk("pending_swap1", {31'd0, swap_pending}, 32'd0);

      // Frame 2 into bank 1: long line, duplicate line_start, overflow line_start
      pulse_fs();
      pulse_ls();
      for (int w = 0; w < 4; w++) send_word(32'hB000_0000 + w, 32'd12 + w);
      send_dropped();
      send_dropped();
      pulse_ls();
      pulse_ls();
      for (int w = 0; w < 4; w++) send_word(32'hB100_0000 + w, 32'd16 + w);
      pulse_ls();
      send_word(32'hB200_0000, 32'd20);
      send_word(32'hB200_0001, 32'd21);
      pulse_ls();
      chk("pending_mid_f2", {31'd0, swap_pending}, 32'd0);
      send_word(32'hB200_0002, 32'd22);
      send_word(32'hB200_0003, 32'd23);
      chk("pending_f2", {31'd0, swap_pending}, 32'd1);
      send_dropped();

      rd_vsync = 1'b1;
      step();
      rd_vsync = 1'b0;
      chk("rd_bank_swap2", {31'd0, rd_bank}, 32'd1);
      chk("rd_base_swap2", {15'd0, rd_base}, 32'd12);

      // Frame 3 completes, then is dropped by an early frame_start
      run_frame(32'd0, 1'b1);
      pulse_fs();
      chk("rd_bank_drop", {31'd0, rd_bank}, 32'd1);
      chk("pending_drop", {31'd0, swap_pending}, 32'd0);
`ifdef FB_STATS_EN
      chk("frames_dropped_1", {16'd0, frames_dropped}, 32'd1);
`endif
      run_frame(32'd0, 1'b0);

      // Simultaneous vsync and frame_start: swap first, then write new bank
      frame_start = 1'b1;
      rd_vsync    = 1'b1;
      step();
      frame_start = 1'b0;
      rd_vsync    = 1'b0;
      chk("rd_bank_simul", {31'd0, rd_bank}, 32'd0);
      chk("rd_base_simul", {15'd0, rd_base}, 32'd0);
      chk("pending_simul", {31'd0, swap_pending}, 32'd0);
      chk("busy_simul", {31'd0, busy}, 32'd1);
`ifdef FB_STATS_EN
      chk("frames_done_4", {16'd0, frames_done}, 32'd4);
      chk("frames_dropped_still1", {16'd0, frames_dropped}, 32'd1);
`endif
      send_word(32'hC000_0000, 32'd12);
      rd_vsync = 1'b1;
      step();
      rd_vsync = 1'b0;
      chk("rd_bank_vsync_active", {31'd0, rd_bank}, 32'd0);
      send_word(32'hC000_0001, 32'd13);

      // Asynchronous reset between clock edges
      #2;
      reset = 1'b1;
      #1;
      chk_reset_outputs("async_reset");
`ifdef FB_STATS_EN
      chk("frames_done_reset", {16'd0, frames_done}, 32'd0);
`endif
      #1;
      reset = 1'b0;

      // Drop enable mid-frame, then restart in the same bank
      step();
      pulse_fs();
      send_word(32'hD000_0000, 32'd0);
      send_word(32'hD000_0001, 32'd1);
      enable = 1'b0;
      step();
      chk("busy_disabled", {31'd0, busy}, 32'd0);
`ifdef FB_STATS_EN
      chk("frames_dropped_en", {16'd0, frames_dropped}, 32'd1);
`endif
      enable = 1'b1;
      step();
      pulse_fs();
      send_word(32'hE000_0000, 32'd0);
      chk("rd_bank_after_en", {31'd0, rd_bank}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
